// File: rtl/control_unit.sv
// Main decoder: maps Opcode/FunctCode to datapath control strobes combinationally.
// Zero latency; a sticky HALT state (entered on opcode 1111, left only by rst) forces every strobe low.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Opcode,
  input  logic [3:0] FunctCode,
  output logic       RegDst,
  output logic       ALUOp1,
  output logic       ALUOp0,
  output logic       ALUSrc,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Jump,
  output logic       RegWrite,
  output logic       MemtoReg,
  output logic       FPC,
  output logic       Stall,
  output logic       Halted
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [3:0] OP_TYPEA  = 4'b0000;
  localparam logic [3:0] OP_LOAD   = 4'b1000;
  localparam logic [3:0] OP_STORE  = 4'b1100;
  localparam logic [3:0] OP_BRANCH = 4'b0100;
  localparam logic [3:0] OP_STALL  = 4'b0111;
  localparam logic [3:0] OP_JUMP   = 4'b1011;
  localparam logic [3:0] OP_HALT   = 4'b1111;
  localparam logic [3:0] FN_FPM    = 4'b0010;

  state_t      state;
  logic [10:0] ctrl;
  logic        stall_dec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else if (state == RUN && Opcode == OP_HALT) begin
      state <= HALT;
    end
  end

  assign Halted = (state == HALT);

  // FunctCode is only looked at under the type-A arm so an undriven field cannot leak X.
  always_comb begin
    ctrl      = 11'b0;
    stall_dec = 1'b0;
    if (!rst && state == RUN) begin
      case (Opcode)
        OP_TYPEA: begin
          ctrl = 11'b11000000100;
          if (FunctCode == FN_FPM) begin
            ctrl[0] = 1'b1;
          end
        end
        OP_LOAD:   ctrl = 11'b00010100110;
        OP_STORE:  ctrl = 11'b00010010000;
        OP_BRANCH: ctrl = 11'b00101000000;
        OP_JUMP:   ctrl = 11'b00000001000;
        OP_STALL:  stall_dec = 1'b1;
        default:   ctrl = 11'b0;
      endcase
    end
  end

  assign {RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead,
          MemWrite, Jump, RegWrite, MemtoReg, FPC} = ctrl;
  assign Stall = stall_dec;

endmodule

// File: tb/tb_control_unit.sv
// Directed plus randomized check of control_unit against a table-driven reference model.
module tb_control_unit;

  logic       clk;
  logic       rst;
  logic [3:0] Opcode;
  logic [3:0] FunctCode;
  logic       RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite;
  logic       Jump, RegWrite, MemtoReg, FPC, Stall, Halted;

  int          vectors;
  int          miscompares;
  logic        m_halted;
  logic [10:0] tbl [16];
  logic [3:0]  xfn;

  control_unit dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .FunctCode(FunctCode),
    .RegDst(RegDst), .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .ALUSrc(ALUSrc),
    .Branch(Branch), .MemRead(MemRead), .MemWrite(MemWrite), .Jump(Jump),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .FPC(FPC), .Stall(Stall),
    .Halted(Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: RegDst ALUOp1 ALUOp0 ALUSrc Branch MemRead MemWrite Jump RegWrite MemtoReg FPC Stall Halted
  function automatic logic [12:0] model_out(input logic [3:0] op, input logic [3:0] fn,
                                            input logic r, input logic h);
    logic [10:0] c;
    if (r) return 13'b0;
    if (h) return 13'b1;
    c = tbl[op];
    if (op == 4'b0000 && fn == 4'b0010) c[0] = 1'b1;
    return {c, (op == 4'b0111), 1'b0};
  endfunction

  task automatic check(input string tag);
    logic [12:0] obs;
    logic [12:0] exp;
    obs = {RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite,
           Jump, RegWrite, MemtoReg, FPC, Stall, Halted};
    exp = model_out(Opcode, FunctCode, rst, m_halted);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive away from the rising edge, check the combinational response, then check after the edge.
  task automatic step(input logic [3:0] op, input logic [3:0] fn, input logic r, input string tag);
    @(negedge clk);
    Opcode    = op;
    FunctCode = fn;
    rst       = r;
    if (r) m_halted = 1'b0;
    #1 check({tag, "/comb"});
    @(posedge clk);
    if (!r && !m_halted && op == 4'b1111) m_halted = 1'b1;
    #1 check({tag, "/edge"});
  endtask

  initial begin
    logic [3:0] op;
    logic [3:0] fn;
    logic       r;
    vectors     = 0;
    miscompares = 0;
    m_halted    = 1'b0;
    xfn         = 4'bxxxx;
    for (int i = 0; i < 16; i++) tbl[i] = 11'b0;
    tbl[4'b0000] = 11'b11000000100;
    tbl[4'b1000] = 11'b00010100110;
    tbl[4'b1100] = 11'b00010010000;
    tbl[4'b0100] = 11'b00101000000;
    tbl[4'b1011] = 11'b00000001000;

    rst       = 1'b1;
    Opcode    = 4'b0000;
    FunctCode = 4'b0001;
    #1 check("reset_t0");

    step(4'b0000, 4'b0001, 1'b1, "reset");
    step(4'b0000, 4'b0001, 1'b0, "typeA");
    step(4'b0000, 4'b0010, 1'b0, "typeA_fpm");
    step(4'b1000, xfn,     1'b0, "load_fnx");
    step(4'b1100, xfn,     1'b0, "store_fnx");
    step(4'b0100, xfn,     1'b0, "branch_fnx");
    step(4'b0111, 4'b0000, 1'b0, "stall");
    step(4'b1011, 4'b0000, 1'b0, "jump");
    step(4'b0001, 4'b0000, 1'b0, "unused_op");
    step(4'b1111, 4'b0000, 1'b0, "halt");
    step(4'b1000, 4'b0000, 1'b0, "halted_load");
    step(4'b0111, 4'b0000, 1'b0, "halted_stall");
    step(4'b1000, 4'b0000, 1'b1, "rst_in_halt");
    step(4'b1000, 4'b0000, 1'b0, "load_after_rst");
    step(4'b1111, 4'b0000, 1'b1, "halt_during_rst");
    step(4'b1000, 4'b0000, 1'b0, "load_no_halt");

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 15));
      if (op != 4'b0000 && $urandom_range(0, 3) == 0) fn = xfn;
      r  = ($urandom_range(0, 11) == 0);
      step(op, fn, r, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Main decoder for the 4-bit-opcode datapath.
- Maps Opcode/FunctCode to datapath control strobes: register destination, ALU op class, ALU source, branch, memory read/write, jump, register write, memory-to-register and floating-point/multiply select (FPC).
- Decode is combinational; a small clocked state machine latches the Halt instruction so the datapath stays quiescent until reset.

Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- Opcode  input  4  instruction opcode field
- FunctCode  input  4  function field; examined only when Opcode = 0000
- RegDst  output  1  1 = write rd (type A), 0 = write rt
- ALUOp1  output  1  ALU op class, high bit
- ALUOp0  output  1  ALU op class, low bit
- ALUSrc  output  1  1 = immediate operand
- Branch  output  1  conditional branch
- MemRead  output  1  data memory read
- MemWrite  output  1  data memory write
- Jump  output  1  unconditional jump
- RegWrite  output  1  register file write enable
- MemtoReg  output  1  1 = writeback from memory
- FPC  output  1  route type-A result through the FPM unit
- Stall  output  1  program-requested stall, current instruction
- Halted  output  1  processor halted, sticky

Behaviour:
- All control outputs are combinational from Opcode/FunctCode, except when gated by state or reset as below. No clock latency; a change on Opcode must be reflected within the same time step.
- FunctCode must not propagate X/Z into any output unless Opcode = 0000. Decode on Opcode first and evaluate FunctCode only inside the type-A branch.

Decode table (output bits listed in order RegDst, ALUOp1, ALUOp0, ALUSrc, Branch, MemRead, MemWrite, Jump, RegWrite, MemtoReg, FPC):
- 0000 type A, FunctCode = 0010 (FPM): 1 1 0 0 0 0 0 0 1 0 1
- 0000 type A, any other FunctCode: 1 1 0 0 0 0 0 0 1 0 0
- 1000 Load: 0 0 0 1 0 1 0 0 1 1 0
- 1100 Store: 0 0 0 1 0 0 1 0 0 0 0
- 0100 Branch: 0 0 1 0 1 0 0 0 0 0 0
- 0111 Stall: all 0; Stall = 1
- 1011 Jump: all 0 except Jump = 1
- 1111 Halt: all 0
- any other opcode: all 0 (NOP)
- Stall = 1 only for opcode 0111; otherwise 0.

State machine:
- States RUN and HALT; Halted = (state == HALT).
- RUN -> HALT on a rising clk edge when Opcode = 1111.
- HALT persists; it is left only via rst.
- In HALT, all eleven control outputs and Stall are forced to 0 regardless of inputs.

Reset:
- rst high immediately (asynchronously) sets state to RUN.
- While rst is high, all outputs are 0, including Halted.
- After rst deasserts, decode resumes combinationally.
- Halt present on the same edge that rst is asserted: reset wins.
- Asserting rst mid-HALT returns the unit to RUN.

Test Plan:
- rst=1, then 0; Opcode=0000, FunctCode=0001 -> RegDst=1, ALUOp=10, RegWrite=1, FPC=0, all others 0, Halted=0.
- Opcode=0000, FunctCode=0010 -> same as previous plus FPC=1. Then Opcode=1000, FunctCode=xxxx -> ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1, others 0, no X on any output.
- Opcode=1100 -> ALUSrc=1, MemWrite=1 only. Opcode=0100 -> ALUOp0=1, Branch=1 only. Both with FunctCode=xxxx and no X.
- Opcode=0111 -> all controls 0, Stall=1. Opcode=1011 -> Jump=1 only.
- Opcode=1111, then clk edge -> Halted=1. Then Opcode=1000 -> all controls still 0. Pulse rst -> Halted=0 and Load decode appears without waiting for a clock.
- Unused opcode 0001 -> all outputs 0. Assert rst while Opcode=1000 -> all outputs 0 immediately.
